// File: rtl/rv32i_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rv32i_pkg                                                        |
// | Purpose  : Shared RV32I load/store encodings, LSU state type and helper    |
// |            functions used by the MEM-stage load/store unit.                 |
// | Contents : funct3 constants, write-back select encoding, lsu_state_t,     |
// |            f3_legal(), addr_aligned().                                      |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package rv32i_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Write-back select value meaning "result comes from memory", i.e. a load
  localparam logic [1:0] WBSEL_MEM = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Stores only have B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural alignment: halves on even bytes, words on 4-byte boundaries.
  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    case (f3)
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : load_formatter                                                   |
// | Purpose  : Combinational lane select and sign/zero extension of a read   |
// |            word according to the load's funct3 and byte offset.          |
// | Ports    : rdata  (in, 32)  raw read word from data memory               |
// |            offset (in, 2)   byte offset of the load address              |
// |            funct3 (in, 3)   load width / signedness                      |
// |            result (out, 32) extended load value                          |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module load_formatter
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase

    // Half-word loads are always even-aligned, so offset[1] picks the half.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    result = rdata;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_stage_lsu                                                    |
// | Purpose  : MEM-stage load/store unit. Issues one registered request per   |
// |            load/store on a req/gnt/rvalid data bus, formats load data and |
// |            stalls the pipeline while the access is outstanding.          |
// | Ports    : clk, rst_n                    clock, async active-low reset    |
// |            ALU_MEM, rs2_MEM, INST_MEM    address, store data, instruction |
// |            MemRW_MEM, WBSel_MEM          store flag, write-back select    |
// |            dmem_req/we/addr/be/wdata     registered bus request (out)     |
// |            dmem_gnt/rvalid/rdata         bus grant and read response (in) |
// |            load_data_MEM                 registered load result (out)     |
// |            stall_MEM                     pipeline hold (out)              |
// |            mem_exc                       misaligned / illegal access (out)|
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_stage_lsu
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [31:0]       ALU_MEM,
  input  logic [31:0]       rs2_MEM,
  input  logic [31:0]       INST_MEM,
  input  logic              MemRW_MEM,
  input  logic [1:0]        WBSel_MEM,

  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,

  output logic [31:0]       load_data_MEM,
  output logic              stall_MEM,
  output logic              mem_exc
);

  // ---------------------------------------------------------------------------
  // Decode of the instruction sitting in MEM
  // ---------------------------------------------------------------------------
  logic [2:0] funct3;
  logic [1:0] byte_off;
  logic       is_store;
  logic       access;
  logic       access_ok;
  logic       start;

  assign funct3    = INST_MEM[14:12];
  assign byte_off  = ALU_MEM[1:0];
  // A store wins if both the store flag and the memory write-back are set.
  assign is_store  = MemRW_MEM;
  assign access    = MemRW_MEM | (WBSel_MEM == WBSEL_MEM);
  assign access_ok = f3_legal(is_store, funct3) & addr_aligned(funct3, byte_off);

  // Only the funct3 field of the instruction is meaningful here.
  logic unused_inst;
  assign unused_inst = ^{INST_MEM[31:15], INST_MEM[11:0]};

  // Store lane steering for the current instruction
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  always_comb begin
    st_be    = 4'hF;
    st_wdata = rs2_MEM;
    case (funct3)
      F3_B: begin
        st_be    = 4'b0001 << byte_off;
        st_wdata = {4{rs2_MEM[7:0]}};
      end
      F3_H: begin
        st_be    = byte_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rs2_MEM[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = rs2_MEM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and request registers
  // ---------------------------------------------------------------------------
  lsu_state_t        state_q,     state_d;
  logic              req_q,       req_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [3:0]        be_q,        be_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [1:0]        off_q,       off_d;
  logic [2:0]        f3_q,        f3_d;
  logic [31:0]       load_data_q, load_data_d;

  logic [31:0] fmt_result;

  // Formatting uses the offset/funct3 latched at request time, so the result
  // does not depend on what the pipeline presents during WAIT.
  load_formatter u_load_formatter (
    .rdata  (dmem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (fmt_result)
  );

  assign start = (state_q == IDLE) & access & access_ok;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    off_d       = off_q;
    f3_d        = f3_q;
    load_data_d = load_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {ALU_MEM[ADDR_W-1:2], 2'b00};
          be_d    = is_store ? st_be : 4'hF;
          wdata_d = st_wdata;
          off_d   = byte_off;
          f3_d    = funct3;
          state_d = REQ;
        end
      end
      REQ: begin
        // Bus fields stay frozen; only req drops once the grant is seen.
        if (dmem_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          load_data_d = fmt_result;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      load_data_q <= load_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign load_data_MEM = load_data_q;

  // DONE deliberately drops the stall so the pipeline advances exactly once.
  assign stall_MEM = start | (state_q == REQ) | (state_q == WAIT);
  assign mem_exc   = (state_q == IDLE) & access & ~access_ok;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_stage_lsu                                                 |
// | Purpose  : Directed scoreboard bench for mem_stage_lsu. Stimulus pushes   |
// |            expected bus transactions / load results; a negedge monitor   |
// |            pops and compares them as the DUT presents them.              |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst_n;
  logic [31:0] ALU_MEM;
  logic [31:0] rs2_MEM;
  logic [31:0] INST_MEM;
  logic        MemRW_MEM;
  logic [1:0]  WBSel_MEM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data_MEM;
  logic        stall_MEM;
  logic        mem_exc;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ALU_MEM       (ALU_MEM),
    .rs2_MEM       (rs2_MEM),
    .INST_MEM      (INST_MEM),
    .MemRW_MEM     (MemRW_MEM),
    .WBSel_MEM     (WBSel_MEM),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .load_data_MEM (load_data_MEM),
    .stall_MEM     (stall_MEM),
    .mem_exc       (mem_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
    int          stall;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge
  // ---------------------------------------------------------------------------
  exp_t        inf;
  logic        have_inf = 1'b0;
  int          stall_cnt = 0;
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_stall = 1'b0;
  logic [68:0] prev_bus = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_inf   = 1'b0;
      stall_cnt  = 0;
      prev_req   = 1'b0;
      prev_gnt   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_req && prev_gnt)
        chk("req_drop_after_gnt", {31'd0, dmem_req}, 32'd0);
      else if (prev_req && dmem_req)
        chk("bus_stable_until_gnt",
            {31'd0, ({dmem_we, dmem_addr, dmem_be, dmem_wdata} != prev_bus)}, 32'd0);

      if (dmem_req && dmem_gnt) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_request", 32'd1, 32'd0);
        end else begin
          inf      = exp_q.pop_front();
          have_inf = 1'b1;
          chk("bus_we",   {31'd0, dmem_we}, {31'd0, ~inf.is_load});
          chk("bus_addr", dmem_addr, inf.addr);
          chk("bus_be",   {28'd0, dmem_be}, {28'd0, inf.be});
          if (!inf.is_load) chk("bus_wdata", dmem_wdata, inf.wdata);
        end
      end

      if (stall_MEM) begin
        stall_cnt++;
      end else if (prev_stall) begin
        // Stall just fell: this is the DONE cycle of the access in flight.
        if (!have_inf) begin
          chk("done_without_grant", 32'd1, 32'd0);
        end else begin
          chk("stall_cycles", stall_cnt, inf.stall);
          if (inf.is_load) chk("load_data", load_data_MEM, inf.ldata);
          have_inf = 1'b0;
        end
        stall_cnt = 0;
      end

      prev_req   = dmem_req;
      prev_gnt   = dmem_gnt;
      prev_stall = stall_MEM;
      prev_bus   = {dmem_we, dmem_addr, dmem_be, dmem_wdata};
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all drive at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic set_idle();
    MemRW_MEM = 1'b0;
    WBSel_MEM = 2'b01;
    ALU_MEM   = 32'h0;
    rs2_MEM   = 32'h0;
    INST_MEM  = 32'h0000_0013;
  endtask

  task automatic drive(input logic st, input logic [1:0] wbsel, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2);
    MemRW_MEM = st;
    WBSel_MEM = wbsel;
    ALU_MEM   = addr;
    rs2_MEM   = rs2;
    INST_MEM  = {17'd0, f3, 5'd0, (st ? 7'h23 : 7'h03)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access: expected response queued, then the bus is played.
  task automatic do_access(input logic st, input logic [1:0] wbsel, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input int gd, input int rd, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_ld);
    exp_t e;
    e.is_load = ~st;
    e.addr    = addr & 32'hFFFF_FFFC;
    e.be      = exp_be;
    e.wdata   = exp_wd;
    e.ldata   = exp_ld;
    e.stall   = st ? (2 + gd) : (3 + gd + rd);
    exp_q.push_back(e);

    drive(st, wbsel, f3, addr, rs2);
    tick();                          // REQ
    repeat (gd) tick();
    dmem_gnt = 1'b1;
    tick();                          // DONE (store) or WAIT (load)
    dmem_gnt = 1'b0;
    if (!st) begin
      repeat (rd) tick();
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      tick();                        // DONE
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;
    end
    tick();                          // back in IDLE
    set_idle();
  endtask

  // Illegal/misaligned access: no request, no stall, load data unchanged.
  task automatic exc_case(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] hold_ld);
    drive(st, st ? 2'b01 : 2'b00, f3, addr, 32'hFFFF_FFFF);
    #1;
    chk({name, "_exc"},   {31'd0, mem_exc},   32'd1);
    chk({name, "_stall"}, {31'd0, stall_MEM}, 32'd0);
    tick();
    chk({name, "_noreq"}, {31'd0, dmem_req},  32'd0);
    chk({name, "_still_idle_exc"}, {31'd0, mem_exc}, 32'd1);
    chk({name, "_ld_hold"}, load_data_MEM, hold_ld);
    set_idle();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n       = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    set_idle();

    #7;
    chk("rst_req",   {31'd0, dmem_req},  32'd0);
    chk("rst_stall", {31'd0, stall_MEM}, 32'd0);
    chk("rst_exc",   {31'd0, mem_exc},   32'd0);
    chk("rst_bus",   dmem_addr | dmem_wdata | {28'd0, dmem_be} | {31'd0, dmem_we}, 32'd0);
    chk("rst_ldata", load_data_MEM, 32'd0);

    tick();
    rst_n = 1'b1;
    tick();

    // Stores (SB also has WBSel=00 to confirm the store takes priority)
    do_access(1, 2'b01, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 4'hF, 32'hDEADBEEF, 32'h0);
    do_access(1, 2'b00, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0, 4'b1000, 32'hA5A5A5A5, 32'h0);
    do_access(1, 2'b01, 3'b001, 32'h106, 32'h1234CAFE, 0, 0, 32'h0, 4'b1100, 32'hCAFECAFE, 32'h0);

    // Loads with lane select and extension
    do_access(0, 2'b00, 3'b000, 32'h102, 32'h0, 0, 0, 32'h12F45678, 4'hF, 32'h0, 32'hFFFFFFF4);
    do_access(0, 2'b00, 3'b100, 32'h102, 32'h0, 0, 0, 32'h12F45678, 4'hF, 32'h0, 32'h000000F4);
    do_access(0, 2'b00, 3'b000, 32'h100, 32'h0, 0, 0, 32'h12F45678, 4'hF, 32'h0, 32'h00000078);
    do_access(0, 2'b00, 3'b100, 32'h101, 32'h0, 0, 1, 32'h12F45678, 4'hF, 32'h0, 32'h00000056);
    do_access(0, 2'b00, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80017FFF, 4'hF, 32'h0, 32'hFFFF8001);
    do_access(0, 2'b00, 3'b101, 32'h100, 32'h0, 0, 0, 32'h80017FFF, 4'hF, 32'h0, 32'h00007FFF);

    // Wait states on grant and response
    do_access(0, 2'b00, 3'b010, 32'h200, 32'h0, 3, 2, 32'h0BADF00D, 4'hF, 32'h0, 32'h0BADF00D);
    do_access(1, 2'b01, 3'b001, 32'h100, 32'h0000BEEF, 2, 0, 32'h0, 4'b0011, 32'hBEEFBEEF, 32'h0);

    // Illegal / misaligned accesses
    exc_case("lh_misaligned", 0, 3'b001, 32'h101, 32'h0BADF00D);
    exc_case("sw_misaligned", 1, 3'b010, 32'h102, 32'h0BADF00D);
    exc_case("store_bad_f3",  1, 3'b100, 32'h100, 32'h0BADF00D);
    exc_case("load_bad_f3",   0, 3'b011, 32'h100, 32'h0BADF00D);

    // Reset while waiting for read data, then a stray response
    begin
      exp_t e;
      e.is_load = 1'b1;
      e.addr    = 32'h300;
      e.be      = 4'hF;
      e.wdata   = 32'h0;
      e.ldata   = 32'h0;
      e.stall   = 0;
      exp_q.push_back(e);
    end
    drive(0, 2'b00, 3'b010, 32'h300, 32'h0);
    tick();                          // REQ
    dmem_gnt = 1'b1;
    tick();                          // WAIT
    dmem_gnt = 1'b0;
    set_idle();
    rst_n = 1'b0;
    #1;
    chk("abort_req",   {31'd0, dmem_req},  32'd0);
    chk("abort_stall", {31'd0, stall_MEM}, 32'd0);
    chk("abort_bus",   dmem_addr | dmem_wdata | {28'd0, dmem_be} | {31'd0, dmem_we}, 32'd0);
    chk("abort_ldata", load_data_MEM, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    tick();
    chk("stray_rvalid_ldata", load_data_MEM, 32'd0);
    chk("stray_rvalid_stall", {31'd0, stall_MEM}, 32'd0);
    chk("stray_rvalid_req",   {31'd0, dmem_req},  32'd0);

    // FSM must be back in IDLE and able to serve a fresh access
    do_access(1, 2'b01, 3'b010, 32'h010, 32'h01234567, 0, 0, 32'h0, 4'hF, 32'h01234567, 32'h0);

    repeat (3) tick();
    chk("all_expected_consumed", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
